shift_chain_sched: RTL and testbench
====================================

Name: shift_chain_sched

Overview:
- Scheduler that shares one single-bit, DEPTH-stage shift chain between two requesters.
- Round-robin arbitration picks one requester and captures its parallel word.
- The word is serialized LSB-first onto the chain's serial input with a shift enable, then the chain is flushed with zeros so the last data bit reaches the chain output.
- Signals completion with the ID of the served requester. Sits between requester logic and the shift register datapath.

Parameters:
- WIDTH, 8, bits per word; legal range >= 2.
- DEPTH, 4, number of flip-flop stages in the downstream chain (flush length); legal range >= 1.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- req, input, 2, per-requester request; held high until own grant bit seen.
- data0, input, WIDTH, requester 0 word; stable while req[0] high.
- data1, input, WIDTH, requester 1 word; stable while req[1] high.
- grant, output, 2, one-cycle registered pulse: word of that requester captured.
- sdo, output, 1, serial data to chain input.
- shift_en, output, 1, chain clock enable; high while shifting or flushing.
- busy, output, 1, high in SHIFT and FLUSH.
- done, output, 1, one-cycle completion pulse.
- done_id, output, 1, requester served; valid when done=1, holds last value otherwise.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - State goes to IDLE.
  - grant=0, sdo=0, shift_en=0, busy=0, done=0, done_id=0.
  - Bit counter=0; round-robin pointer = requester 0 preferred.
  - Reset mid-transaction aborts it silently: no done, partial word discarded.
- States: IDLE, SHIFT, FLUSH; all outputs registered.
- IDLE:
  - At an edge with req != 0, arbitration selects a requester:
    - Single requester: that one wins.
    - Both requesting: the preferred one (pointer) wins.
  - Winner's data is captured into the shift register, counter cleared, state goes to SHIFT.
  - Pointer updates to prefer the non-winner.
  - grant[winner]=1 for exactly the following cycle, which is the first SHIFT cycle.
  - Idle outputs: sdo=0, shift_en=0.
- SHIFT:
  - Lasts WIDTH cycles; cycle i (i=0..WIDTH-1) drives sdo=word[i] with shift_en=1.
  - After cycle WIDTH-1, state goes to FLUSH with counter cleared.
- FLUSH:
  - Lasts DEPTH cycles; sdo=0, shift_en=1.
  - After the last FLUSH cycle, state goes to IDLE.
  - In that first IDLE cycle: done=1, done_id=winner, busy=0, shift_en=0.
- Timing: capture edge E.
  - grant: cycle 1.
  - Data bits: cycles 1..WIDTH.
  - Flush: cycles WIDTH+1..WIDTH+DEPTH.
  - done: cycle WIDTH+DEPTH+1.
- Back-to-back: IDLE arbitrates during the done cycle, so the next grant can occur at cycle WIDTH+DEPTH+2 with no further gap.
- Requests during SHIFT/FLUSH are ignored: no grant, pointer unchanged, no data sampled.
- A requester that drops req before grant simply loses its turn; there is no queuing.
- Counter width is clog2(max(WIDTH, DEPTH)) bits. The terminal compare is done exactly at WIDTH-1 and DEPTH-1; no wrap beyond.

Test Plan:
- Reset, then req=2'b01, data0=8'hA5 -> grant=01 next cycle; sdo sequence 1,0,1,0,0,1,0,1 with shift_en=1; 4 zero-flush cycles; done=1, done_id=0 at cycle 13; a 4-stage chain output shows A5 LSB-first.
- req=2'b11 held, data0=8'h0F, data1=8'hF0 -> served order 0,1,0,1; each done_id matches; the second grant arrives 1 cycle after the first done.
- Single requester re-requesting continuously (req=2'b10) -> served every 13 cycles; grant[1] pulses at cycles 1, 14, 27.
- req[0] raised mid-SHIFT of requester 1 -> no grant until requester 1's done cycle; grant[0] the cycle after.
- rst_n=0 during FLUSH cycle 2 -> all outputs 0 the next cycle; no done; next req=2'b11 is granted to requester 0.
- Parameter sweep WIDTH=2, DEPTH=1 with data1=2'b10 -> sdo 0,1, then 0 for 1 flush cycle; done at cycle 4.

Source files
------------

// File: rtl/shift_chain_sched.sv
// Round-robin scheduler sharing one DEPTH-stage serial chain between two requesters:
// grant 1 cycle after capture, WIDTH data bits LSB-first, DEPTH zero flush, then done; requests ignored while busy.
module shift_chain_sched #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       grant,
  output logic             sdo,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  localparam int MAXL = (WIDTH > DEPTH) ? WIDTH : DEPTH;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             ptr;
  logic             winner;
  logic             pick;
  logic [WIDTH-1:0] sel_word;

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    pick = ptr;
    if (req == 2'b01)
      pick = 1'b0;
    else if (req == 2'b10)
      pick = 1'b1;
    sel_word = pick ? data1 : data0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      ptr      <= 1'b0;
      winner   <= 1'b0;
      grant    <= 2'b00;
      sdo      <= 1'b0;
      shift_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_id  <= 1'b0;
    end else begin
      grant <= 2'b00;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state    <= SHIFT;
            cnt      <= '0;
            // bit 0 goes straight to sdo; the rest waits in shreg
            sdo      <= sel_word[0];
            shreg    <= sel_word >> 1;
            shift_en <= 1'b1;
            busy     <= 1'b1;
            grant    <= pick ? 2'b10 : 2'b01;
            winner   <= pick;
            ptr      <= ~pick;
          end
        end
        SHIFT: begin
          if (cnt == W_LAST) begin
            state <= FLUSH;
            cnt   <= '0;
            sdo   <= 1'b0;
          end else begin
            cnt   <= cnt + 1'b1;
            sdo   <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        FLUSH: begin
          if (cnt == D_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            done_id  <= winner;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_chain_sched.sv
// Bench for shift_chain_sched: timeline model of two instances (8/4 and 2/1) plus directed literal checks.
module tb_shift_chain_sched;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_a, req_b;
  logic [7:0] data0_a, data1_a;
  logic [1:0] data0_b, data1_b;
  logic [1:0] grant_a, grant_b;
  logic       sdo_a, shift_en_a, busy_a, done_a, done_id_a;
  logic       sdo_b, shift_en_b, busy_b, done_b, done_id_b;

  int n_chk  = 0;
  int n_fail = 0;

  shift_chain_sched #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .data0(data0_a), .data1(data1_a),
    .grant(grant_a), .sdo(sdo_a), .shift_en(shift_en_a), .busy(busy_a),
    .done(done_a), .done_id(done_id_a)
  );

  shift_chain_sched #(.WIDTH(2), .DEPTH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .data0(data0_b), .data1(data1_b),
    .grant(grant_b), .sdo(sdo_b), .shift_en(shift_en_b), .busy(busy_b),
    .done(done_b), .done_id(done_id_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: each transaction is a timeline; k counts cycles since the capture edge.
  int         wp[2] = '{8, 2};
  int         dp[2] = '{4, 1};
  bit         mv = 1'b0;
  bit         act[2];
  int         k[2];
  logic [7:0] wd[2];
  logic       wn[2];
  logic       ptr[2];
  logic       lid[2];
  logic [1:0] m_r;
  logic [7:0] m_d0, m_d1;
  logic       m_win;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_r  = (i == 0) ? req_a : req_b;
      m_d0 = (i == 0) ? data0_a : {6'b0, data0_b};
      m_d1 = (i == 0) ? data1_a : {6'b0, data1_b};
      if (!rst_n) begin
        mv = 1'b1; act[i] = 1'b0; k[i] = 0; ptr[i] = 1'b0; lid[i] = 1'b0;
      end else if (mv) begin
        if ((!act[i] || k[i] >= wp[i] + dp[i] + 1) && m_r != 2'b00) begin
          m_win  = (m_r == 2'b11) ? ptr[i] : m_r[1];
          act[i] = 1'b1;
          k[i]   = 1;
          wd[i]  = m_win ? m_d1 : m_d0;
          wn[i]  = m_win;
          ptr[i] = ~m_win;
        end else if (act[i]) begin
          k[i]++;
          if (k[i] > wp[i] + dp[i] + 1) act[i] = 1'b0;
        end
        if (act[i] && k[i] == wp[i] + dp[i] + 1) lid[i] = wn[i];
      end
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      for (int i = 0; i < 2; i++) begin
        logic [1:0] eg;
        logic es, ee, ed;
        eg = (act[i] && k[i] == 1) ? (wn[i] ? 2'b10 : 2'b01) : 2'b00;
        es = (act[i] && k[i] >= 1 && k[i] <= wp[i]) ? wd[i][k[i]-1] : 1'b0;
        ee = act[i] && k[i] <= wp[i] + dp[i];
        ed = act[i] && k[i] == wp[i] + dp[i] + 1;
        chk($sformatf("m%0d_grant", i),    (i == 0) ? grant_a : grant_b, eg);
        chk($sformatf("m%0d_sdo", i),      (i == 0) ? sdo_a : sdo_b, es);
        chk($sformatf("m%0d_shift_en", i), (i == 0) ? shift_en_a : shift_en_b, ee);
        chk($sformatf("m%0d_busy", i),     (i == 0) ? busy_a : busy_b, ee);
        chk($sformatf("m%0d_done", i),     (i == 0) ? done_a : done_b, ed);
        chk($sformatf("m%0d_done_id", i),  (i == 0) ? done_id_a : done_id_b, lid[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_a = 2'b00; req_b = 2'b00;
    tick();
    chk("rst_grant", grant_a, 0);
    chk("rst_sdo", sdo_a, 0);
    chk("rst_shift_en", shift_en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_done_id", done_id_a, 0);
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] next_req(input logic [1:0] r, input logic [1:0] g);
    logic [3:0] v;
    v = {2'b00, r};
    for (int j = 0; j < 2; j++) begin
      if (!r[j]) begin
        if ($urandom_range(0, 3) == 0) begin v[j] = 1'b1; v[j+2] = 1'b1; end
      end else if (g[j]) begin
        if ($urandom_range(0, 1) == 0) v[j] = 1'b0;
      end else if ($urandom_range(0, 31) == 0) begin
        v[j] = 1'b0;
      end
    end
    return v;
  endfunction

  initial begin
    logic [7:0] word;
    logic [3:0] chain;
    logic [7:0] coll;
    int         nsh;
    int         ng, nd;
    logic       gord[4];
    logic       dids[4];
    logic       prev_done;
    int         gt[3];
    int         ngt;
    logic [3:0] v;

    rst_n = 1'b0; req_a = 2'b00; req_b = 2'b00;
    data0_a = 8'h00; data1_a = 8'h00; data0_b = 2'b00; data1_b = 2'b00;

    // single request, A5 out LSB-first through a 4-stage chain
    apply_reset();
    req_a = 2'b01; data0_a = 8'hA5; word = 8'hA5;
    chain = 4'b0; coll = 8'h00; nsh = 0;
    tick();
    for (int c = 1; c <= 13; c++) begin
      if (c == 1) begin chk("t1_grant", grant_a, 2'b01); req_a = 2'b00; end
      chk("t1_sdo", sdo_a, (c <= 8) ? word[c-1] : 1'b0);
      chk("t1_shift_en", shift_en_a, c <= 12);
      chk("t1_done", done_a, c == 13);
      if (c == 13) chk("t1_done_id", done_id_a, 0);
      if (shift_en_a) begin
        chain = {chain[2:0], sdo_a};
        nsh++;
        if (nsh >= 4 && nsh <= 11) coll[nsh-4] = chain[3];
      end
      tick();
    end
    chk("t1_chain_out", coll, 8'hA5);

    // both requesting continuously: alternating service, no gap after done
    apply_reset();
    req_a = 2'b11; data0_a = 8'h0F; data1_a = 8'hF0;
    ng = 0; nd = 0; prev_done = 1'b0;
    tick();
    for (int c = 1; c <= 55; c++) begin
      if (grant_a != 2'b00 && ng < 4) begin gord[ng] = grant_a[1]; ng++; end
      if (done_a && nd < 4) begin dids[nd] = done_id_a; nd++; end
      if (prev_done) chk("t2_grant_after_done", grant_a != 2'b00, 1);
      prev_done = done_a;
      tick();
    end
    req_a = 2'b00;
    chk("t2_grants", ng, 4);
    chk("t2_dones", nd, 4);
    for (int j = 0; j < ng; j++) chk("t2_order", gord[j], j % 2);
    for (int j = 0; j < nd; j++) chk("t2_done_id", dids[j], j % 2);

    // lone requester 1 re-requesting: period WIDTH+DEPTH+1
    apply_reset();
    req_a = 2'b10; data1_a = 8'h3C; ngt = 0;
    tick();
    for (int c = 1; c <= 27; c++) begin
      if (grant_a[1]) begin
        if (ngt < 3) gt[ngt] = c;
        ngt++;
      end
      tick();
    end
    req_a = 2'b00;
    chk("t3_grant_count", ngt, 3);
    chk("t3_grant0_cycle", gt[0], 1);
    chk("t3_grant1_cycle", gt[1], 14);
    chk("t3_grant2_cycle", gt[2], 27);

    // req[0] arriving mid-SHIFT waits for the done cycle
    apply_reset();
    req_a = 2'b10; data1_a = 8'h5A;
    tick();
    for (int c = 1; c <= 14; c++) begin
      if (c == 1) begin chk("t4_grant1", grant_a, 2'b10); req_a = 2'b00; end
      if (c == 3) begin req_a = 2'b01; data0_a = 8'h33; end
      if (c >= 2 && c <= 13) chk("t4_no_grant", grant_a, 0);
      if (c == 13) chk("t4_done", done_a, 1);
      if (c == 14) chk("t4_grant0", grant_a, 2'b01);
      tick();
    end
    req_a = 2'b00;

    // reset in the second flush cycle aborts silently and re-prefers requester 0
    apply_reset();
    req_a = 2'b01; data0_a = 8'hC3;
    tick();
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) req_a = 2'b00;
      tick();
    end
    chk("t5_in_flush", shift_en_a && !busy_a == 1'b0 && sdo_a == 1'b0, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_grant", grant_a, 0);
    chk("t5_sdo", sdo_a, 0);
    chk("t5_shift_en", shift_en_a, 0);
    chk("t5_busy", busy_a, 0);
    chk("t5_done", done_a, 0);
    rst_n = 1'b1; req_a = 2'b11; data0_a = 8'h11; data1_a = 8'h22;
    tick();
    chk("t5_regrant", grant_a, 2'b01);
    chk("t5_no_done", done_a, 0);
    req_a = 2'b00;

    // small instance WIDTH=2 DEPTH=1
    apply_reset();
    req_b = 2'b10; data1_b = 2'b10;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 1) begin chk("t6_grant", grant_b, 2'b10); req_b = 2'b00; end
      chk("t6_sdo", sdo_b, c == 2);
      chk("t6_shift_en", shift_en_b, c <= 3);
      chk("t6_done", done_b, c == 4);
      if (c == 4) chk("t6_done_id", done_id_b, 1);
      tick();
    end

    // randomized traffic on both instances, occasional reset
    for (int t = 0; t < 3000; t++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      v = next_req(req_a, grant_a);
      req_a = v[1:0];
      if (v[2]) data0_a = 8'($urandom);
      if (v[3]) data1_a = 8'($urandom);
      v = next_req(req_b, grant_b);
      req_b = v[1:0];
      if (v[2]) data0_b = 2'($urandom);
      if (v[3]) data1_b = 2'($urandom);
      tick();
    end
    rst_n = 1'b1; req_a = 2'b00; req_b = 2'b00;
    for (int c = 0; c < 20; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
